iot_event_serializer: RTL and testbench
=======================================

Name: iot_event_serializer

Overview:
- Upstream feeder for the active-device counter.
- Watches N_DEV per-device on/off status lines, detects status edges, and queues one pending event per device.
- Issues at most one event per clock as a change/on_off pulse pair, selected round-robin, so the counter (one event per cycle) never misses a simultaneous power-up or power-down.

Parameters:
- N_DEV, 8, number of monitored device status lines (2..32)
- ID_W, $clog2(N_DEV), width of dev_id output

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- dev_status  input  N_DEV  per-device status, 1=on; already synchronised to clk
- change  output  1  registered; 1 for one cycle per issued event
- on_off  output  1  registered; 1=device turned on (count up), 0=turned off (count down); valid only when change=1, else 0
- dev_id  output  ID_W  registered; index of device for current event; 0 when change=0
- pending_any  output  1  registered; 1 if any device still has an unissued event after this edge

Behaviour:
- Reset (rst=1 at posedge):
  - change=0, on_off=0, dev_id=0, pending_any=0.
  - All pending states=NONE; rr_ptr=0; prev_q=0 (all devices treated as off).
  - Devices already on when rst deasserts therefore produce UP events, matching the downstream counter restarting at 0.
  - Reset wins over every other activity, including mid-burst; queued events are discarded.
- Edge detection:
  - prev_q[i] <= dev_status[i] every non-reset posedge.
  - rise[i] = dev_status[i] & ~prev_q[i]; fall[i] = ~dev_status[i] & prev_q[i] (combinational).
- Per-device pending state: NONE, UP, DOWN (2 bits each). Updated at each posedge in two ordered steps:
  1. If device i is granted this edge, its state becomes NONE.
  2. Then apply the edge:
     - rise: NONE->UP; DOWN->NONE (cancel, net zero).
     - fall: NONE->DOWN; UP->NONE (cancel).
     - rise with UP, or fall with DOWN, cannot occur; state holds.
- Example: device granted UP at the same edge a fall arrives -> UP issued, state becomes DOWN.
- Arbiter:
  - Candidates are devices with state != NONE, sampled before the update.
  - Grant the lowest index >= rr_ptr, wrapping modulo N_DEV.
  - On grant: change<=1, on_off<=(state==UP), dev_id<=index, rr_ptr<=(index+1) mod N_DEV.
  - No candidate: change<=0, on_off<=0, dev_id<=0, rr_ptr holds.
- Latency:
  - dev_status edge sampled at posedge k -> pending set at k.
  - Earliest change pulse is registered at k+1, i.e. visible in the cycle after edge k+1.
  - Worst case k+N_DEV when all devices are pending.
- pending_any:
  - Registered OR of the post-update states.
  - 1 while a backlog remains; 0 once the last event has issued and no new edges arrived.
- Throughput: one event per cycle sustained; no event is lost and no drop path exists.
- Net-count invariant: after quiescence, (#UP issued − #DOWN issued) since reset equals popcount(dev_status).

Test Plan:
- Reset with dev_status=8'h00, then dev_status[3] 0->1 -> exactly one cycle change=1, on_off=1, dev_id=3, two edges after sampling; pending_any=0 afterwards.
- All 8 devices rise in the same cycle from rr_ptr=0 -> 8 consecutive change pulses, dev_id 0..7 in order, on_off=1 each; pending_any=1 for the first 7, then 0.
- Device 5 rises, then falls on the very next edge before it is granted (device 2 backlog keeps the arbiter busy) -> device 5 event cancelled; no pulse with dev_id=5; net count unchanged.
- Grant of device 1 UP coincides with a fall on device 1 -> UP pulse issued (dev_id=1, on_off=1), then a DOWN pulse for dev_id=1 in a later cycle.
- Round-robin fairness: rr_ptr=6 with devices 0, 2 and 6 pending -> grant order 6, 0, 2.
- Assert rst mid-burst with 4 events pending -> next cycle change=0, pending_any=0; after release with dev_status=8'h81 -> UP pulses for dev_id 0, then 7; randomized run checks the net-count invariant against popcount.

Source files
------------

// File: rtl/iot_event_serializer.sv
// Serialises per-device on/off status edges into one change/on_off event per clock,
// keeping one pending event per device and arbitrating round-robin.
module iot_event_serializer #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = $clog2(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_status,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             pending_any
);
   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_UP   = 2'd1,
      PEND_DOWN = 2'd2
   } pend_t;

   pend_t            pend_q [N_DEV];
   pend_t            pend_d [N_DEV];
   logic [N_DEV-1:0] prev_q;
   logic [N_DEV-1:0] rise;
   logic [N_DEV-1:0] fall;
   logic [N_DEV-1:0] cand;
   logic [ID_W-1:0]  rr_ptr_q;
   logic             grant_vld;
   logic             grant_up;
   logic [ID_W-1:0]  grant_idx;
   logic             hi_vld;
   logic             hi_up;
   logic [ID_W-1:0]  hi_idx;
   logic             lo_up;
   logic [ID_W-1:0]  lo_idx;
   logic             pend_any_d;

   assign rise = dev_status & ~prev_q;
   assign fall = ~dev_status & prev_q;

   always_comb begin
      cand = '0;
      for (int i = 0; i < int'(N_DEV); i++) begin
         cand[i] = (pend_q[i] != PEND_NONE);
      end
   end

   // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall (wrap).
   always_comb begin
      hi_vld    = 1'b0;
      hi_up     = 1'b0;
      hi_idx    = '0;
      lo_up     = 1'b0;
      lo_idx    = '0;
      grant_vld = 1'b0;
      for (int i = int'(N_DEV) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            grant_vld = 1'b1;
            lo_idx    = ID_W'(i);
            lo_up     = (pend_q[i] == PEND_UP);
            if (i >= int'(rr_ptr_q)) begin
               hi_vld = 1'b1;
               hi_idx = ID_W'(i);
               hi_up  = (pend_q[i] == PEND_UP);
            end
         end
      end
      grant_idx = hi_vld ? hi_idx : lo_idx;
      grant_up  = hi_vld ? hi_up : lo_up;
   end

   // Pending update: clear the granted device first, then fold in this edge.
   always_comb begin
      pend_any_d = 1'b0;
      for (int i = 0; i < int'(N_DEV); i++) begin
         pend_d[i] = pend_q[i];
         if (grant_vld && (grant_idx == ID_W'(i))) begin
            pend_d[i] = PEND_NONE;
         end
         if (rise[i]) begin
            if (pend_d[i] == PEND_NONE) begin
               pend_d[i] = PEND_UP;
            end else if (pend_d[i] == PEND_DOWN) begin
               pend_d[i] = PEND_NONE;
            end
         end else if (fall[i]) begin
            if (pend_d[i] == PEND_NONE) begin
               pend_d[i] = PEND_DOWN;
            end else if (pend_d[i] == PEND_UP) begin
               pend_d[i] = PEND_NONE;
            end
         end
         pend_any_d = pend_any_d | (pend_d[i] != PEND_NONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= '0;
         rr_ptr_q    <= '0;
         change      <= 1'b0;
         on_off      <= 1'b0;
         dev_id      <= '0;
         pending_any <= 1'b0;
         for (int i = 0; i < int'(N_DEV); i++) begin
            pend_q[i] <= PEND_NONE;
         end
      end else begin
         prev_q      <= dev_status;
         pending_any <= pend_any_d;
         change      <= grant_vld;
         on_off      <= grant_vld & grant_up;
         dev_id      <= grant_vld ? grant_idx : '0;
         for (int i = 0; i < int'(N_DEV); i++) begin
            pend_q[i] <= pend_d[i];
         end
         if (grant_vld) begin
            rr_ptr_q <= (grant_idx == ID_W'(N_DEV - 1)) ? '0 : grant_idx + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_iot_event_serializer.sv
// Scoreboard bench for iot_event_serializer: directed arbitration/cancel/reset cases
// plus a random run checking issued levels against dev_status after quiescence.
module tb_iot_event_serializer;
   localparam int unsigned N_DEV = 8;
   localparam int unsigned ID_W  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_DEV-1:0] dev_status = '0;
   logic             change;
   logic             on_off;
   logic [ID_W-1:0]  dev_id;
   logic             pending_any;

   logic [3:0]       exp_q[$];
   logic [N_DEV-1:0] lvl;
   int               net;
   bit               sb_on;
   int               n_vec;
   int               n_err;

   iot_event_serializer #(.N_DEV(N_DEV), .ID_W(ID_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .dev_status  (dev_status),
      .change      (change),
      .on_off      (on_off),
      .dev_id      (dev_id),
      .pending_any (pending_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge, then sample outputs and retire any issued event.
   task automatic step();
      logic [3:0] e;
      @(posedge clk);
      #1;
      if (change) begin
         net += on_off ? 1 : -1;
         check("lvl_toggle", 32'(lvl[dev_id]), 32'(!on_off));
         lvl[dev_id] = on_off;
         if (sb_on) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("event", 32'({on_off, dev_id}), 32'(e));
            end
         end
      end else begin
         check("idle_on_off", 32'(on_off), 32'd0);
         check("idle_dev_id", 32'(dev_id), 32'd0);
      end
   endtask

   task automatic drain();
      int n = 0;
      step();
      while ((exp_q.size() != 0 || pending_any || change) && n < 40) begin
         step();
         n++;
      end
      check("drain_q", 32'(exp_q.size()), 32'd0);
      check("drain_pend", 32'(pending_any), 32'd0);
   endtask

   task automatic do_reset(input logic [N_DEV-1:0] st);
      dev_status = st;
      rst        = 1'b1;
      step();
      check("rst_change", 32'(change), 32'd0);
      check("rst_pend", 32'(pending_any), 32'd0);
      rst = 1'b0;
      lvl = '0;
      net = 0;
      exp_q.delete();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      net   = 0;
      lvl   = '0;
      sb_on = 1'b1;

      // Power-on reset state
      rst = 1'b1;
      dev_status = '0;
      step();
      step();
      check("rst_change0", 32'(change), 32'd0);
      check("rst_on_off0", 32'(on_off), 32'd0);
      check("rst_dev_id0", 32'(dev_id), 32'd0);
      check("rst_pend0", 32'(pending_any), 32'd0);
      rst = 1'b0;
      step();

      // Single rise on device 3: pending at edge k, pulse at k+1
      dev_status[3] = 1'b1;
      exp_q.push_back({1'b1, 3'd3});
      step();
      check("t1_pend", 32'(pending_any), 32'd1);
      check("t1_not_early", 32'(exp_q.size()), 32'd1);
      step();
      check("t1_issued", 32'(exp_q.size()), 32'd0);
      check("t1_pend_after", 32'(pending_any), 32'd0);
      step();

      // All eight rise together from rr_ptr=0
      do_reset('0);
      dev_status = 8'hFF;
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 3'(i)});
      step();
      check("t2_pend", 32'(pending_any), 32'd1);
      for (int j = 0; j < 8; j++) begin
         step();
         check("t2_q", 32'(exp_q.size()), 32'(7 - j));
         check("t2_pend_seq", 32'(pending_any), 32'(j < 7));
      end
      drain();

      // Device 5 rise cancelled by fall while device 2 holds the grant
      do_reset('0);
      dev_status = 8'h24;
      exp_q.push_back({1'b1, 3'd2});
      step();
      dev_status[5] = 1'b0;
      drain();
      check("t3_net", 32'(net), 32'($countones(dev_status)));

      // Grant of device 1 UP coincides with its fall
      do_reset('0);
      dev_status[1] = 1'b1;
      exp_q.push_back({1'b1, 3'd1});
      exp_q.push_back({1'b0, 3'd1});
      step();
      dev_status[1] = 1'b0;
      step();
      check("t4_up_first", 32'(exp_q.size()), 32'd1);
      drain();
      check("t4_net", 32'(net), 32'd0);

      // Round-robin wrap from rr_ptr=6
      do_reset('0);
      dev_status[5] = 1'b1;
      exp_q.push_back({1'b1, 3'd5});
      drain();
      dev_status = 8'h65;
      exp_q.push_back({1'b1, 3'd6});
      exp_q.push_back({1'b1, 3'd0});
      exp_q.push_back({1'b1, 3'd2});
      drain();
      check("t5_net", 32'(net), 32'($countones(dev_status)));

      // Reset with four events queued discards them
      do_reset('0);
      dev_status = 8'h0F;
      step();
      check("t6_pend", 32'(pending_any), 32'd1);
      rst = 1'b1;
      step();
      check("t6_rst_change", 32'(change), 32'd0);
      check("t6_rst_pend", 32'(pending_any), 32'd0);
      dev_status = 8'h81;
      step();
      rst = 1'b0;
      lvl = '0;
      net = 0;
      exp_q.push_back({1'b1, 3'd0});
      exp_q.push_back({1'b1, 3'd7});
      drain();
      check("t6_net", 32'(net), 32'd2);

      // Random toggling, then quiesce and compare issued levels to dev_status
      do_reset('0);
      sb_on = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            dev_status = dev_status ^ (8'($urandom) & 8'($urandom));
         end
         step();
      end
      drain();
      check("rand_lvl", 32'(lvl), 32'(dev_status));
      check("rand_net", 32'(net), 32'($countones(dev_status)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
